// File: rtl/mem_pkg.sv
// Shared definitions for the wait-state memory: FSM encoding and wait counter width.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/mem_array.sv
// Word storage with two prioritised synchronous write ports and one combinational read port.
// Port A (transaction) beats port B (preload) on a same-edge, same-address collision.
module mem_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents survive reset; port A is written last so it wins a collision.
  always_ff @(posedge clk) begin
    if (b_we) mem[b_addr] <= b_data;
    if (a_we) mem[a_addr] <= a_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/wait_state_memory.sv
// Single-port bus memory with WAIT_STATES extra cycles; ready pulses WAIT_STATES+1 edges after acceptance.
// The CPU holds read/write until ready; requests arriving in BUSY/ACK are ignored.
module wait_state_memory
  import mem_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] memoryIn,
  output logic [DATA_W-1:0] memoryOut,
  output logic              ready,
  output logic              busy,
  output logic              err,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  state_t                  state, state_nx;
  logic [WAIT_CNT_W-1:0]   cnt;
  logic                    op_wr;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       data_q;
  logic [DATA_W-1:0]       rd_data;
  logic                    accept, both_req, done;

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    both_req = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (read && write) begin
          both_req = 1'b1;
        end else if (read || write) begin
          accept   = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          done     = 1'b1;
          state_nx = ACK;
        end
      end
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      cnt       <= '0;
      op_wr     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      memoryOut <= '0;
      ready     <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_nx;
      ready <= done;
      if (both_req) err <= 1'b1;
      if (accept) begin
        op_wr  <= write;
        addr_q <= address;
        data_q <= memoryIn;
        cnt    <= WAIT_CNT_W'(WAIT_STATES);
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      // Array read sees pre-edge contents, so a same-edge preload is not visible here.
      if (done && !op_wr) memoryOut <= rd_data;
    end
  end

  assign busy = (state != IDLE);

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .a_we    (done && op_wr),
    .a_addr  (addr_q),
    .a_data  (data_q),
    .b_we    (load_en),
    .b_addr  (load_addr),
    .b_data  (load_data),
    .rd_addr (addr_q),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_wait_state_memory.sv
// Directed bench: one instance with WAIT_STATES=2 and one with WAIT_STATES=0.
module tb_wait_state_memory;

  logic       clk = 1'b0;
  logic       clr;
  int         errors = 0;
  int         checks = 0;

  // Instance A: WAIT_STATES = 2
  logic       a_read, a_write, a_ready, a_busy, a_err, a_lden;
  logic [3:0] a_addr, a_laddr;
  logic [7:0] a_din, a_dout, a_ldata;

  // Instance B: WAIT_STATES = 0
  logic       b_read, b_write, b_ready, b_busy, b_err, b_lden;
  logic [3:0] b_addr, b_laddr;
  logic [7:0] b_din, b_dout, b_ldata;

  always #5 clk = ~clk;

  wait_state_memory #(.DATA_W(8), .ADDR_W(4), .WAIT_STATES(2)) u_a (
    .clk(clk), .clr(clr), .read(a_read), .write(a_write), .address(a_addr),
    .memoryIn(a_din), .memoryOut(a_dout), .ready(a_ready), .busy(a_busy), .err(a_err),
    .load_en(a_lden), .load_addr(a_laddr), .load_data(a_ldata)
  );

  wait_state_memory #(.DATA_W(8), .ADDR_W(4), .WAIT_STATES(0)) u_b (
    .clk(clk), .clr(clr), .read(b_read), .write(b_write), .address(b_addr),
    .memoryIn(b_din), .memoryOut(b_dout), .ready(b_ready), .busy(b_busy), .err(b_err),
    .load_en(b_lden), .load_addr(b_laddr), .load_data(b_ldata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_a(input logic [3:0] ad, input logic [7:0] d);
    a_lden = 1'b1; a_laddr = ad; a_ldata = d;
    tick();
    a_lden = 1'b0;
  endtask

  // One transaction on A; optionally preloads cd to the same address on the completing edge.
  task automatic txn_a(input logic wr, input logic [3:0] ad, input logic [7:0] d,
                       input bit coll, input logic [7:0] cd, input string tag);
    int n;
    a_read = ~wr; a_write = wr; a_addr = ad; a_din = d;
    tick();
    check({tag, ":busy"}, 32'(a_busy), 32'd1);
    n = 0;
    while (a_ready !== 1'b1 && n < 20) begin
      if (coll && n == 2) begin
        a_lden = 1'b1; a_laddr = ad; a_ldata = cd;
      end
      tick();
      a_lden = 1'b0;
      n++;
    end
    check({tag, ":lat"}, 32'(n), 32'd3);
    a_read = 1'b0; a_write = 1'b0;
    tick();
    check({tag, ":idle"}, 32'({a_ready, a_busy}), 32'd0);
  endtask

  initial begin
    int  n;
    logic seen;
    clr = 1'b0;
    a_read = 0; a_write = 0; a_addr = 0; a_din = 0; a_lden = 0; a_laddr = 0; a_ldata = 0;
    b_read = 0; b_write = 0; b_addr = 0; b_din = 0; b_lden = 0; b_laddr = 0; b_ldata = 0;
    tick();
    clr = 1'b1;
    tick();

    load_a(4'd0, 8'h17); load_a(4'd1, 8'h00); load_a(4'd2, 8'h5A);
    load_a(4'd3, 8'h33); load_a(4'd4, 8'h44); load_a(4'd6, 8'h02);
    load_a(4'd7, 8'h03);
    b_lden = 1'b1; b_laddr = 4'd6; b_ldata = 8'h02;
    tick();
    b_lden = 1'b0;

    clr = 1'b0;
    #1;
    check("rst:dout", 32'(a_dout), 32'h0);
    check("rst:ready", 32'(a_ready), 32'd0);
    check("rst:busy", 32'(a_busy), 32'd0);
    check("rst:err", 32'(a_err), 32'd0);
    check("rst:b_busy", 32'(b_busy), 32'd0);
    tick();
    clr = 1'b1;
    tick();

    txn_a(1'b0, 4'd7, 8'h00, 1'b0, 8'h00, "rd7");
    check("rd7:data", 32'(a_dout), 32'h03);

    txn_a(1'b1, 4'd1, 8'h54, 1'b0, 8'h00, "wr1");
    check("wr1:dout_held", 32'(a_dout), 32'h03);
    txn_a(1'b0, 4'd1, 8'h00, 1'b0, 8'h00, "rd1");
    check("rd1:data", 32'(a_dout), 32'h54);
    txn_a(1'b0, 4'd2, 8'h00, 1'b0, 8'h00, "rd2");
    check("rd2:data", 32'(a_dout), 32'h5A);

    // Zero wait states: ready the cycle after acceptance, held read repeats every 3 edges.
    b_read = 1'b1; b_addr = 4'd6;
    tick();
    check("ws0:acc_ready", 32'({b_ready, b_busy}), 32'b01);
    tick();
    check("ws0:ready", 32'(b_ready), 32'd1);
    check("ws0:data", 32'(b_dout), 32'h02);
    n = 0;
    do begin
      tick();
      n++;
    end while (b_ready !== 1'b1 && n < 10);
    check("ws0:spacing", 32'(n), 32'd3);
    b_read = 1'b0;
    tick();
    tick();
    check("ws0:idle", 32'({b_ready, b_busy}), 32'd0);

    // Simultaneous read and write: error flag, no access.
    a_read = 1'b1; a_write = 1'b1; a_addr = 4'd2; a_din = 8'hEE;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen = seen | a_ready | a_busy;
    end
    check("both:err", 32'(a_err), 32'd1);
    check("both:no_activity", 32'(seen), 32'd0);
    a_read = 1'b0; a_write = 1'b0;
    tick();
    check("both:err_sticky", 32'(a_err), 32'd1);
    clr = 1'b0;
    #1;
    check("both:err_cleared", 32'(a_err), 32'd0);
    tick();
    clr = 1'b1;
    tick();
    txn_a(1'b0, 4'd2, 8'h00, 1'b0, 8'h00, "rd2b");
    check("rd2b:data", 32'(a_dout), 32'h5A);

    // Reset while BUSY abandons the write.
    a_write = 1'b1; a_addr = 4'd0; a_din = 8'hFF;
    tick();
    check("rstbusy:busy", 32'(a_busy), 32'd1);
    tick();
    clr = 1'b0;
    #1;
    check("rstbusy:async", 32'({a_ready, a_busy}), 32'd0);
    a_write = 1'b0;
    tick();
    tick();
    clr = 1'b1;
    tick();
    check("rstbusy:ready", 32'(a_ready), 32'd0);
    txn_a(1'b0, 4'd0, 8'h00, 1'b0, 8'h00, "rd0");
    check("rd0:data", 32'(a_dout), 32'h17);

    // Transaction write beats a same-edge preload to the same word.
    txn_a(1'b1, 4'd3, 8'h55, 1'b1, 8'hAA, "coll");
    txn_a(1'b0, 4'd3, 8'h00, 1'b0, 8'h00, "rd3");
    check("rd3:data", 32'(a_dout), 32'h55);

    // A read completing with a same-edge preload returns the old contents.
    txn_a(1'b0, 4'd4, 8'h00, 1'b1, 8'h99, "rdpl");
    check("rdpl:old", 32'(a_dout), 32'h44);
    txn_a(1'b0, 4'd4, 8'h00, 1'b0, 8'h00, "rd4");
    check("rd4:new", 32'(a_dout), 32'h99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
